mem_arbiter: RTL and testbench

//   Shares the single-port synchronous memory between two masters: m0 (cpu) and m1 (loader/DMA/debug port).

---
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for a single-port synchronous memory.
// Define MEM_ARB_FIXED_PRIO_EN to give m0 fixed priority (m1 cannot preempt m0).
module mem_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_HOLD   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_data,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_data,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_in
);
   localparam int HW = $clog2(MAX_HOLD) + 1;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, nxt;
   logic last;
   logic [HW-1:0] hold_cnt;
   logic acc0, acc1, cap0, cap1, pick1, other_req;
   assign acc0 = m0_gnt & m0_req;
   assign acc1 = m1_gnt & m1_req;
   assign cap1 = m0_req && hold_cnt == HW'(MAX_HOLD - 1);
`ifdef MEM_ARB_FIXED_PRIO_EN
   assign cap0  = 1'b0;
   assign pick1 = 1'b0;
`else
   assign cap0  = m1_req && hold_cnt == HW'(MAX_HOLD - 1);
   assign pick1 = ~last;
`endif
   assign other_req = (state == OWN0) ? m1_req : m0_req;
   always_comb begin
      nxt = IDLE;
      case (state)
         OWN0:    nxt = !m0_req ? (m1_req ? OWN1 : IDLE) : cap0 ? OWN1 : OWN0;
         OWN1:    nxt = !m1_req ? (m0_req ? OWN0 : IDLE) : cap1 ? OWN0 : OWN1;
         default: nxt = (m0_req & m1_req) ? (pick1 ? OWN1 : OWN0) : m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         last      <= 1'b1;
         hold_cnt  <= '0;
      end else begin
         state     <= nxt;
         m0_gnt    <= nxt == OWN0;
         m1_gnt    <= nxt == OWN1;
         m0_rvalid <= acc0 & ~m0_we;
         m1_rvalid <= acc1 & ~m1_we;
         last      <= nxt == OWN0 ? 1'b0 : nxt == OWN1 ? 1'b1 : last;
         hold_cnt  <= (nxt != state || nxt == IDLE || !other_req) ? '0 : hold_cnt + 1'b1;
      end
   end
   // Read data is tagged by the registered rvalid, so the issuer gets it even after a grant switch.
   assign m0_rdata = mem_in;
   assign m1_rdata = mem_in;
   assign mem_we   = (acc0 & m0_we) | (acc1 & m1_we);
   assign mem_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
   assign mem_data = m0_gnt ? m0_data : m1_gnt ? m1_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural memory.
module tb_mem_arbiter;
   localparam int AW = 6;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_data = '0, m1_data = '0;
   logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
   logic [DW-1:0] m0_rdata, m1_rdata, mem_data;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_in = '0;
   logic [DW-1:0] mem [0:63];
   int total = 0;
   int bad = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data(m0_data),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data(m1_data),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_in <= mem[mem_addr];
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset;
      rst_n = 0;
      m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0;
      cyc(2);
      rst_n = 1;
   endtask
   initial begin
      logic e0, e1, p0, p1;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[5] = 16'h00AB;
      mem[3] = 16'h0055;
      cyc(2);
      check("rst_gnt0", m0_gnt, 0);
      check("rst_gnt1", m1_gnt, 0);
      check("rst_rv0", m0_rvalid, 0);
      check("rst_rv1", m1_rvalid, 0);
      check("rst_we", mem_we, 0);
      rst_n = 1;
      // single m0 read
      cyc(1);
      m0_req = 1; m0_addr = 5;
      check("t1_idle_addr", mem_addr, 0);
      cyc(1);
      check("t1_gnt0", m0_gnt, 1);
      check("t1_gnt1", m1_gnt, 0);
      check("t1_rv0_early", m0_rvalid, 0);
      check("t1_addr", mem_addr, 5);
      cyc(1);
      check("t1_rv0", m0_rvalid, 1);
      check("t1_rdata", m0_rdata, 16'h00AB);
      check("t1_gnt1b", m1_gnt, 0);
      m0_req = 0;
      cyc(1);
      check("t1_rv0_once", m0_rvalid, 0);
      check("t1_gnt0_off", m0_gnt, 0);
      // both request, m0 releases, no bubble
      do_reset;
      m0_req = 1; m0_addr = 5; m1_req = 1; m1_addr = 3;
      cyc(1);
      check("t2_gnt0", m0_gnt, 1);
      check("t2_gnt1", m1_gnt, 0);
      cyc(2);
      check("t2_rv0", m0_rvalid, 1);
      m0_req = 0;
      cyc(1);
      check("t2_sw_gnt1", m1_gnt, 1);
      check("t2_sw_gnt0", m0_gnt, 0);
      check("t2_sw_rv0", m0_rvalid, 0);
      cyc(1);
      check("t2_rv1", m1_rvalid, 1);
      check("t2_rdata1", m1_rdata, 16'h0055);
      m1_req = 0;
      cyc(1);
      // sustained contention: rotation every 8 cycles, rvalid follows issuer
      do_reset;
      m0_req = 1; m0_addr = 5; m1_req = 1; m1_addr = 3;
      cyc(1);
      p0 = 0; p1 = 0;
      for (int k = 0; k < 24; k++) begin
         e0 = FIXED ? 1'b1 : ((k / 8) % 2 == 0);
         e1 = ~e0;
         check($sformatf("t3_gnt0_%0d", k), m0_gnt, e0);
         check($sformatf("t3_gnt1_%0d", k), m1_gnt, e1);
         if (k > 0) begin
            check($sformatf("t3_rv0_%0d", k), m0_rvalid, p0);
            check($sformatf("t3_rv1_%0d", k), m1_rvalid, p1);
            if (p0) check($sformatf("t3_rd0_%0d", k), m0_rdata, 16'h00AB);
            if (p1) check($sformatf("t3_rd1_%0d", k), m1_rdata, 16'h0055);
         end
         p0 = e0; p1 = e1;
         cyc(1);
      end
      m0_req = 0; m1_req = 0;
      cyc(1);
      // non-owner write is held off until grant
      do_reset;
      m0_req = 1; m0_addr = 5;
      m1_req = 1; m1_we = 1; m1_addr = 3; m1_data = 16'h1234;
      cyc(1);
      check("t4_gnt0", m0_gnt, 1);
      check("t4_we_blocked", mem_we, 0);
      cyc(2);
      check("t4_mem_unch", mem[3], 16'h0055);
      m0_req = 0;
      cyc(1);
      check("t4_gnt1", m1_gnt, 1);
      check("t4_we", mem_we, 1);
      check("t4_mem_pre", mem[3], 16'h0055);
      cyc(1);
      check("t4_mem_wr", mem[3], 16'h1234);
      check("t4_no_rv1", m1_rvalid, 0);
      m1_req = 0; m1_we = 0;
      cyc(1);
      // async reset in the middle of an m1 read
      do_reset;
      m1_req = 1; m1_addr = 3;
      cyc(1);
      check("t5_gnt1", m1_gnt, 1);
      cyc(1);
      check("t5_rv1", m1_rvalid, 1);
      check("t5_rd1", m1_rdata, 16'h1234);
      #2 rst_n = 0;
      #1;
      check("t5_rst_gnt1", m1_gnt, 0);
      check("t5_rst_rv1", m1_rvalid, 0);
      m1_we = 1; m1_data = 16'hBEEF;
      #1;
      check("t5_rst_we", mem_we, 0);
      @(negedge clk);
      check("t5_no_wr", mem[3], 16'h1234);
      m1_we = 0; m0_req = 1; m0_addr = 5;
      rst_n = 1;
      cyc(1);
      check("t5_tie_gnt0", m0_gnt, 1);
      check("t5_tie_gnt1", m1_gnt, 0);
`ifdef MEM_ARB_FIXED_PRIO_EN
      // fixed priority: m0 keeps the bus under contention
      do_reset;
      m0_req = 1; m1_req = 1;
      cyc(1);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("t6_gnt0_%0d", k), m0_gnt, 1);
         check($sformatf("t6_gnt1_%0d", k), m1_gnt, 0);
         cyc(1);
      end
`endif
      m0_req = 0; m1_req = 0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
